// File: rtl/kiwi_perf_monitor.sv
// Top-down performance counters and end-of-test halt detection for the dual-issue kiwi core.
// Eight saturating counters are read through a one-cycle-latency request/response port. SLOTS must be 2.
module kiwi_perf_monitor #(
  parameter int unsigned CNT_W     = 64,
  parameter logic [31:0] HALT_INST = 32'h0000_006b,
  parameter int unsigned SLOTS     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cnt_en_i,
  input  logic             clr_i,
  input  logic             dec0_vld_i,
  input  logic             dec1_vld_i,
  input  logic [31:0]      dec0_inst_i,
  input  logic [31:0]      dec1_inst_i,
  input  logic             backend_stall_i,
  input  logic             flush_i,
  input  logic             retire0_i,
  input  logic             retire1_i,
  input  logic             rd_req_i,
  input  logic [2:0]       rd_sel_i,
  output logic             rd_vld_o,
  output logic [CNT_W-1:0] rd_data_o,
  output logic             halt_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam int unsigned NCNT = 8;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q   [NCNT];
  logic [CNT_W-1:0] cnt_inc [NCNT];
  logic [CNT_W-1:0] cnt_d   [NCNT];
  logic [1:0]       inc     [NCNT];
  logic [1:0]       n_vld;
  logic             halt_hit;
  logic             count_en;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign halt_hit = (dec0_vld_i && (dec0_inst_i == HALT_INST)) ||
                    (dec1_vld_i && (dec1_inst_i == HALT_INST));
  assign count_en = (state_q == S_RUN) && cnt_en_i;
  assign n_vld    = {1'b0, dec0_vld_i} + {1'b0, dec1_vld_i};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (cnt_en_i) state_d = S_RUN;
      S_RUN:    if (!cnt_en_i) state_d = S_IDLE;
                else if (halt_hit) state_d = S_HALTED;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
    if (clr_i) state_d = S_IDLE;
  end

  always_comb begin
    inc[0] = 2'd1;
    inc[1] = 2'(SLOTS);
    inc[2] = n_vld;
    inc[3] = {1'b0, retire0_i} + {1'b0, retire1_i};
    inc[4] = backend_stall_i ? 2'd0 : n_vld;
    inc[5] = backend_stall_i ? n_vld : 2'd0;
    inc[6] = {1'b0, flush_i};
    inc[7] = 2'(SLOTS) - n_vld;
    for (int unsigned i = 0; i < NCNT; i++) begin
      cnt_inc[i] = count_en ? sat_add(cnt_q[i], inc[i]) : cnt_q[i];
      cnt_d[i]   = clr_i ? '0 : cnt_inc[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Read data comes from the pre-clear value so a read colliding with clr_i still returns the old count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCNT; i++) cnt_q[i] <= '0;
      rd_vld_o  <= 1'b0;
      rd_data_o <= '0;
    end else begin
      for (int unsigned i = 0; i < NCNT; i++) cnt_q[i] <= cnt_d[i];
      rd_vld_o <= rd_req_i;
      if (rd_req_i) rd_data_o <= cnt_inc[rd_sel_i];
    end
  end

  assign halt_o  = (state_q == S_HALTED);
  assign state_o = state_q;

endmodule

// File: tb/tb_kiwi_perf_monitor.sv
// Directed bench for kiwi_perf_monitor: counting, halt freeze, saturation, clear/read collision, async reset.
module tb_kiwi_perf_monitor;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cnt_en_i, clr_i;
  logic        dec0_vld_i, dec1_vld_i;
  logic [31:0] dec0_inst_i, dec1_inst_i;
  logic        backend_stall_i, flush_i, retire0_i, retire1_i;
  logic        rd_req_i;
  logic [2:0]  rd_sel_i;
  logic        rd_vld_o;
  logic [63:0] rd_data_o;
  logic        halt_o;
  logic [1:0]  state_o;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [2:0] C_CYC = 3'd0, C_SLT = 3'd1, C_INS = 3'd2, C_RET = 3'd3,
                         C_FE  = 3'd4, C_BE  = 3'd5, C_FL  = 3'd6, C_BUB = 3'd7;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  kiwi_perf_monitor #(.CNT_W(64), .HALT_INST(32'h0000_006b), .SLOTS(2)) dut (
    .clk(clk), .rst_n(rst_n), .cnt_en_i(cnt_en_i), .clr_i(clr_i),
    .dec0_vld_i(dec0_vld_i), .dec1_vld_i(dec1_vld_i),
    .dec0_inst_i(dec0_inst_i), .dec1_inst_i(dec1_inst_i),
    .backend_stall_i(backend_stall_i), .flush_i(flush_i),
    .retire0_i(retire0_i), .retire1_i(retire1_i),
    .rd_req_i(rd_req_i), .rd_sel_i(rd_sel_i),
    .rd_vld_o(rd_vld_o), .rd_data_o(rd_data_o),
    .halt_o(halt_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [2:0] sel, input logic [63:0] exp, input string tag);
    rd_req_i = 1'b1;
    rd_sel_i = sel;
    tick();
    rd_req_i = 1'b0;
    chk({tag, "_vld"}, 64'(rd_vld_o), 64'd1);
    chk(tag, rd_data_o, exp);
  endtask

  task automatic clear();
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cnt_en_i = 0; clr_i = 0;
    dec0_vld_i = 0; dec1_vld_i = 0; dec0_inst_i = 32'h13; dec1_inst_i = 32'h13;
    backend_stall_i = 0; flush_i = 0; retire0_i = 0; retire1_i = 0;
    rd_req_i = 0; rd_sel_i = '0;
    #12 rst_n = 1'b1;
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_halt", 64'(halt_o), 64'd0);
    chk("rst_vld", 64'(rd_vld_o), 64'd0);
    chk("rst_data", rd_data_o, 64'd0);
    tick();

    // 10 cycles full dual issue
    cnt_en_i = 1; dec0_vld_i = 1; dec1_vld_i = 1; retire0_i = 1; retire1_i = 1;
    tick();
    chk("run_state", 64'(state_o), 64'd1);
    for (int i = 0; i < 9; i++) tick();
    rd_req_i = 1; rd_sel_i = C_CYC;
    tick();
    rd_req_i = 0;
    chk("inflight_cyc", rd_data_o, 64'd10);
    cnt_en_i = 0;
    tick();
    chk("idle_state", 64'(state_o), 64'd0);
    rd(C_CYC, 64'd10, "t1_cyc");
    rd(C_SLT, 64'd20, "t1_slots");
    rd(C_INS, 64'd20, "t1_ins");
    rd(C_FE,  64'd20, "t1_fe");
    rd(C_RET, 64'd20, "t1_ret");
    rd(C_BUB, 64'd0,  "t1_bub");
    rd(C_BE,  64'd0,  "t1_be");
    tick();
    chk("pulse_vld", 64'(rd_vld_o), 64'd0);
    chk("hold_data", rd_data_o, 64'd0);
    clear();
    rd(C_CYC, 64'd0, "clr_cyc");

    // 8 cycles single issue with stalls and flushes
    cnt_en_i = 1; dec1_vld_i = 0; retire1_i = 0;
    tick();
    for (int i = 0; i < 8; i++) begin
      backend_stall_i = (i == 1 || i == 4 || i == 6);
      flush_i = (i == 2 || i == 5);
      tick();
    end
    backend_stall_i = 0; flush_i = 0; cnt_en_i = 0;
    tick();
    rd(C_INS, 64'd8,  "t2_ins");
    rd(C_BE,  64'd3,  "t2_be");
    rd(C_FE,  64'd5,  "t2_fe");
    rd(C_BUB, 64'd8,  "t2_bub");
    rd(C_FL,  64'd2,  "t2_flush");
    rd(C_RET, 64'd8,  "t2_ret");
    rd(C_SLT, 64'd16, "t2_slots");
    clear();

    // halt on slot 1 in RUN cycle 5
    cnt_en_i = 1; dec1_vld_i = 1;
    tick();
    for (int c = 1; c <= 5; c++) begin
      dec1_inst_i = (c == 5) ? 32'h0000_006b : 32'h13;
      tick();
      if (c == 4) chk("pre_halt", 64'(halt_o), 64'd0);
    end
    dec1_inst_i = 32'h13;
    chk("halt_o", 64'(halt_o), 64'd1);
    chk("halt_state", 64'(state_o), 64'd2);
    for (int i = 0; i < 20; i++) tick();
    rd(C_CYC, 64'd5,  "halt_cyc");
    rd(C_INS, 64'd10, "halt_ins");
    cnt_en_i = 0;
    tick();
    chk("halt_sticky", 64'(state_o), 64'd2);
    clear();
    chk("clr_state", 64'(state_o), 64'd0);
    chk("clr_halt", 64'(halt_o), 64'd0);

    // saturation: cycles +1 and slots +2 both near the top
    dut.cnt_q[0] = ONES - 64'd1;
    dut.cnt_q[1] = ONES - 64'd1;
    cnt_en_i = 1;
    tick();
    for (int i = 0; i < 3; i++) tick();
    cnt_en_i = 0;
    tick();
    rd(C_CYC, ONES, "sat_cyc");
    rd(C_SLT, ONES, "sat_slots");
    rd(C_INS, 64'd6, "sat_ins");
    clear();

    // clear colliding with a read of 40 instructions
    cnt_en_i = 1;
    tick();
    for (int i = 0; i < 20; i++) tick();
    cnt_en_i = 0;
    tick();
    clr_i = 1; rd_req_i = 1; rd_sel_i = C_INS;
    tick();
    clr_i = 0; rd_req_i = 0;
    chk("clrrd_vld", 64'(rd_vld_o), 64'd1);
    chk("clrrd_data", rd_data_o, 64'd40);
    rd(C_INS, 64'd0, "clrrd_after");
    chk("clrrd_state", 64'(state_o), 64'd0);

    // async reset mid-RUN with a response showing and a request pending
    cnt_en_i = 1;
    tick();
    for (int i = 0; i < 3; i++) tick();
    rd_req_i = 1; rd_sel_i = C_CYC;
    tick();
    chk("pre_rst_vld", 64'(rd_vld_o), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_vld", 64'(rd_vld_o), 64'd0);
    chk("arst_data", rd_data_o, 64'd0);
    chk("arst_state", 64'(state_o), 64'd0);
    chk("arst_cyc", dut.cnt_q[0], 64'd0);
    rd_req_i = 0; cnt_en_i = 0;
    tick();
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_vld0", 64'(rd_vld_o), 64'd0);
    tick();
    chk("post_rst_vld1", 64'(rd_vld_o), 64'd0);
    rd(C_CYC, 64'd0, "post_rst_cyc");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/kiwi_perf_monitor.md
Name: kiwi_perf_monitor

Overview:
- Synthesizable top-down (TMA) performance-counter and halt-detect unit for the kiwi core.
- Sits directly downstream of the dual-issue decoder and commit logic. Taps per-slot decode valid/instruction, backend stall, pipeline flush and per-slot retire.
- Accumulates cycle, slot and category counters, and raises a halt flag when the end-of-test instruction is decoded.
- Counters are read through a simple one-cycle-latency request/response port, so benches and future CSR logic stop peeking into hierarchy.

Parameters:
- CNT_W, 64, width of every counter. Counters saturate at all-ones.
- HALT_INST, 32'h0000_006b, decoded instruction word that ends simulation.
- SLOTS, 2, issue width. Fixed at 2 in this revision; any other value is illegal.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- cnt_en_i  in  1  start/enable counting
- clr_i  in  1  synchronous clear of all counters; returns FSM to IDLE
- dec0_vld_i  in  1  decode slot 0 valid
- dec1_vld_i  in  1  decode slot 1 valid
- dec0_inst_i  in  32  decode slot 0 instruction
- dec1_inst_i  in  32  decode slot 1 instruction
- backend_stall_i  in  1  backend not accepting decode this cycle
- flush_i  in  1  pipeline flush pulse
- retire0_i  in  1  commit slot 0
- retire1_i  in  1  commit slot 1
- rd_req_i  in  1  counter read request
- rd_sel_i  in  3  counter select: 0 cycles, 1 slots, 2 instructions, 3 retired, 4 frontend, 5 backend, 6 flush_cycles, 7 bubbles
- rd_vld_o  out  1  read data valid
- rd_data_o  out  CNT_W  read data
- halt_o  out  1  end-of-test instruction observed; sticky
- state_o  out  2  FSM state: 0 IDLE, 1 RUN, 2 HALTED

Behaviour:
- Reset: all counters 0, FSM IDLE, halt_o 0, rd_vld_o 0, rd_data_o 0, state_o 0.
- IDLE → RUN: on cnt_en_i=1, effective the next cycle. The enabling cycle is not counted.
- RUN → IDLE: when cnt_en_i=0. Counters hold their values; the cycle in which cnt_en_i drops is not counted.
- RUN → HALTED: when any valid decode slot carries HALT_INST.
  - The halting cycle is fully counted.
  - From the next cycle, counters freeze and halt_o=1.
- HALTED is left only by clr_i or reset.
- clr_i has priority over all events. Next cycle: all counters 0, halt_o 0, FSM IDLE.
- Per RUN cycle, each slot s in {0,1}:
  - cycles += 1; slots += 2.
  - If decs_vld: instructions += 1, then backend += 1 if backend_stall_i, else frontend += 1.
  - If decs_vld is 0: bubbles += 1.
  - retired += retire0_i + retire1_i (0..2).
  - flush_cycles += flush_i.
- All increments for one cycle land together on the next edge.
- Saturation: a counter at all-ones stays at all-ones. Each counter saturates independently.
- Halt detect: slot 1 is checked even when slot 0 is also valid. Both slots holding HALT_INST gives a single halt.
- Read port: rd_req_i sampled at edge N → rd_vld_o=1 with rd_data_o = value of the selected counter after edge N (includes the increment of that cycle).
  - rd_vld_o is a single-cycle pulse per request.
  - Back-to-back requests are allowed, one response per cycle.
  - Reads are legal in every state and never stall counting.
  - rd_data_o holds its last value when rd_vld_o=0.
- Reset asserted mid-operation: immediate return to reset values. Any read response in flight is dropped.
- Derived TMA figures (flush recovery = flush_cycles*4*SLOTS, bad speculation = instructions - retired) are computed by software or the bench, not in this block.

Test Plan:
- Reset, then cnt_en_i=1 for 10 cycles with both decode valid, no stall, retire0=retire1=1 → cycles=10, slots=20, instructions=20, frontend=20, retired=20, bubbles=0.
- RUN 8 cycles: dec0 valid every cycle, dec1 never, backend_stall on 3 of the cycles, flush_i on 2 → instructions=8, backend=3, frontend=5, bubbles=8, flush_cycles=2.
- dec1_inst_i=32'h0000_006b with dec1_vld_i in RUN cycle 5 → halt_o=1 from cycle 6, cycles reads 5 and stays 5 for 20 further cycles, state_o=2.
- Force cycles to all-ones minus 1 (via bench deposit), run 3 cycles → reads all-ones, no wrap to 0.
- clr_i asserted in the same cycle as a read of instructions=40 → rd_data_o=40, next read returns 0, state_o=0.
- Deassert rst_n asynchronously mid-RUN with a rd_req_i pending → rd_vld_o=0 and all counters 0 immediately; no response after reset is released.
